// File: rtl/uart_tx_frame_gen.sv
// UART transmitter: start bit, LSB-first data, optional even/odd parity, one stop bit.
// Each bit is held for Prescale clock cycles (0 behaves as 1).
module uart_tx_frame_gen #(
  parameter int DATA_WIDTH     = 8,
  parameter int Prescale_Width = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      Data_Valid,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [Prescale_Width-1:0] Prescale,
  output logic                      TX_OUT,
  output logic                      Busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [3:0] BIT_LAST = 4'(DATA_WIDTH - 1);

  state_t                    state_reg;
  logic [Prescale_Width-1:0] edge_cnt_reg;
  logic [Prescale_Width-1:0] prescale_reg;
  logic [3:0]                bit_cnt_reg;
  logic [DATA_WIDTH-1:0]     shift_reg;
  logic                      par_en_reg;
  logic                      par_bit_reg;
  logic                      tx_out_reg;
  logic                      busy_reg;

  logic [DATA_WIDTH:0]       par_chain;
  logic                      parity_in;
  logic [Prescale_Width-1:0] edge_last;
  logic                      bit_end;
  logic [DATA_WIDTH-1:0]     shift_next;

  // Parity of the incoming byte, seeded with PAR_TYP so odd parity inverts it.
  assign par_chain[0] = PAR_TYP;
  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_parity
      assign par_chain[gi+1] = par_chain[gi] ^ P_DATA[gi];
    end
  endgenerate
  assign parity_in = par_chain[DATA_WIDTH];

  assign edge_last  = (prescale_reg == '0) ? '0 : prescale_reg - Prescale_Width'(1);
  assign bit_end    = (edge_cnt_reg == edge_last);
  assign shift_next = shift_reg >> 1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= IDLE;
      edge_cnt_reg <= '0;
      prescale_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      par_en_reg   <= 1'b0;
      par_bit_reg  <= 1'b0;
      tx_out_reg   <= 1'b1;
      busy_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          tx_out_reg <= 1'b1;
          busy_reg   <= 1'b0;
          if (Data_Valid) begin
            shift_reg    <= P_DATA;
            par_en_reg   <= PAR_EN;
            par_bit_reg  <= parity_in;
            prescale_reg <= Prescale;
            edge_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            tx_out_reg   <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= START;
          end
        end

        START: begin
          if (bit_end) begin
            edge_cnt_reg <= '0;
            tx_out_reg   <= shift_reg[0];
            state_reg    <= DATA;
          end else begin
            edge_cnt_reg <= edge_cnt_reg + Prescale_Width'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            edge_cnt_reg <= '0;
            bit_cnt_reg  <= bit_cnt_reg + 4'd1;
            shift_reg    <= shift_next;
            if (bit_cnt_reg == BIT_LAST) begin
              if (par_en_reg) begin
                tx_out_reg <= par_bit_reg;
                state_reg  <= PARITY;
              end else begin
                tx_out_reg <= 1'b1;
                state_reg  <= STOP;
              end
            end else begin
              tx_out_reg <= shift_next[0];
            end
          end else begin
            edge_cnt_reg <= edge_cnt_reg + Prescale_Width'(1);
          end
        end

        PARITY: begin
          if (bit_end) begin
            edge_cnt_reg <= '0;
            tx_out_reg   <= 1'b1;
            state_reg    <= STOP;
          end else begin
            edge_cnt_reg <= edge_cnt_reg + Prescale_Width'(1);
          end
        end

        STOP: begin
          // Busy drops with the stop bit's last edge, guaranteeing one IDLE cycle.
          if (bit_end) begin
            edge_cnt_reg <= '0;
            tx_out_reg   <= 1'b1;
            busy_reg     <= 1'b0;
            state_reg    <= IDLE;
          end else begin
            edge_cnt_reg <= edge_cnt_reg + Prescale_Width'(1);
          end
        end

        default: begin
          edge_cnt_reg <= '0;
          tx_out_reg   <= 1'b1;
          busy_reg     <= 1'b0;
          state_reg    <= IDLE;
        end
      endcase
    end
  end

  assign TX_OUT = tx_out_reg;
  assign Busy   = busy_reg;

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Bench for uart_tx_frame_gen: per-cycle comparison against a frame-level line model,
// plus literal line patterns and busy lengths for each directed frame.
module tb_uart_tx_frame_gen;

  localparam int DW = 8;
  localparam int PW = 6;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [DW-1:0] P_DATA = '0;
  logic          Data_Valid = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic [PW-1:0] Prescale = '0;
  logic          TX_OUT;
  logic          Busy;

  int total = 0;
  int bad   = 0;

  uart_tx_frame_gen #(.DATA_WIDTH(DW), .Prescale_Width(PW)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .Prescale(Prescale),
    .TX_OUT(TX_OUT), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line model: on acceptance, queue the whole frame, one entry per clock cycle.
  logic exp_q[$];
  logic cur_tx   = 1'b1;
  logic cur_busy = 1'b0;
  logic model_ok = 1'b0;

  task automatic push_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                            input logic [PW-1:0] pre);
    int p;
    int n;
    logic [15:0] bits;
    p = (pre == 0) ? 1 : int'(pre);
    bits = '0;
    bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) bits[1+i] = d[i];
    n = DW + 1;
    if (pe) begin
      bits[n] = (($countones(d) % 2) == 1) ^ pt;
      n++;
    end
    bits[n] = 1'b1;
    n++;
    for (int s = 0; s < n; s++)
      for (int r = 0; r < p; r++) exp_q.push_back(bits[s]);
  endtask

  always @(posedge CLK) begin
    if (RST) begin
      exp_q.delete();
      cur_tx   = 1'b1;
      cur_busy = 1'b0;
      model_ok = 1'b1;
    end else begin
      if (!cur_busy && Data_Valid) push_frame(P_DATA, PAR_EN, PAR_TYP, Prescale);
      if (exp_q.size() > 0) begin
        cur_tx   = exp_q.pop_front();
        cur_busy = 1'b1;
      end else begin
        cur_tx   = 1'b1;
        cur_busy = 1'b0;
      end
    end
  end

  always @(negedge CLK) begin
    if (model_ok) begin
      check("cyc_tx_out", 32'(TX_OUT), 32'(cur_tx));
      check("cyc_busy", 32'(Busy), 32'(cur_busy));
    end
  end

  // Frame monitor: captures the line while Busy is high and the idle gap before it.
  logic trace_q[$];
  logic last_trace[$];
  logic prev_busy   = 1'b0;
  int   idle_cnt    = 0;
  int   last_gap    = 0;
  int   last_len    = 0;
  int   frames_done = 0;

  always @(negedge CLK) begin
    if (model_ok) begin
      if (Busy === 1'b1) begin
        if (!prev_busy) begin
          last_gap = idle_cnt;
          trace_q.delete();
        end
        trace_q.push_back(TX_OUT);
        prev_busy = 1'b1;
      end else begin
        if (prev_busy) begin
          last_trace  = trace_q;
          last_len    = trace_q.size();
          frames_done++;
          idle_cnt    = 0;
        end
        idle_cnt++;
        prev_busy = 1'b0;
      end
    end
  end

  task automatic wait_frames(input int target, input string name);
    int n;
    n = 0;
    while (frames_done < target && n < 3000) begin
      @(negedge CLK);
      #1;
      n++;
    end
    if (frames_done < target) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got frames=%0d expected frames=%0d", name, frames_done, target);
    end
  endtask

  task automatic check_frame(input string name, input int p, input int nbits,
                             input logic [15:0] exp_vec, input int exp_len);
    logic [15:0] act;
    int idx;
    act = '0;
    for (int i = 0; i < nbits; i++) begin
      idx = i * p + p / 2;
      if (idx < last_trace.size()) act[i] = last_trace[idx];
    end
    $display("frame %s: line=%0h busy_cycles=%0d", name, act, last_len);
    check({name, "_busy_len"}, 32'(last_len), 32'(exp_len));
    check({name, "_bits"}, 32'(act), 32'(exp_vec));
  endtask

  task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt,
                      input logic [PW-1:0] pre);
    @(posedge CLK);
    #1;
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Prescale = pre; Data_Valid = 1'b1;
    @(posedge CLK);
    #1;
    Data_Valid = 1'b0;
  endtask

  int f;

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check("reset_tx_out", 32'(TX_OUT), 32'd1);
    check("reset_busy", 32'(Busy), 32'd0);

    f = frames_done;
    send(8'hA5, 1'b0, 1'b0, 6'd8);
    wait_frames(f + 1, "a5");
    check_frame("a5_p8", 8, 10, 16'h034A, 80);

    send(8'h03, 1'b1, 1'b0, 6'd4);
    wait_frames(f + 2, "03e");
    check_frame("03_even_p4", 4, 11, 16'h0406, 44);

    send(8'h03, 1'b1, 1'b1, 6'd4);
    wait_frames(f + 3, "03o");
    check_frame("03_odd_p4", 4, 11, 16'h0606, 44);

    // Data_Valid held high; P_DATA changes mid-frame.
    f = frames_done;
    @(posedge CLK);
    #1;
    P_DATA = 8'h5A; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd4; Data_Valid = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    P_DATA = 8'hFF;
    wait_frames(f + 1, "5a");
    check_frame("held_5a", 4, 10, 16'h02B4, 40);
    @(posedge CLK);
    #1;
    Data_Valid = 1'b0;
    wait_frames(f + 2, "ff");
    check_frame("held_ff", 4, 10, 16'h03FE, 40);
    check("held_idle_gap", 32'(last_gap), 32'd1);

    // Reset 20 cycles into a frame, with Data_Valid in the same cycle.
    @(posedge CLK);
    #1;
    P_DATA = 8'hC3; PAR_EN = 1'b0; Prescale = 6'd8; Data_Valid = 1'b1;
    @(posedge CLK);
    #1;
    Data_Valid = 1'b0;
    repeat (19) @(posedge CLK);
    #1;
    check("pre_reset_busy", 32'(Busy), 32'd1);
    RST = 1'b1; Data_Valid = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0; Data_Valid = 1'b0;
    @(negedge CLK);
    check("abort_tx_out", 32'(TX_OUT), 32'd1);
    check("abort_busy", 32'(Busy), 32'd0);
    repeat (3) @(negedge CLK);
    check("abort_dv_dropped", 32'(Busy), 32'd0);

    f = frames_done;
    send(8'h3C, 1'b1, 1'b0, 6'd2);
    wait_frames(f + 1, "3c");
    check_frame("post_reset_3c_p2", 2, 11, 16'h0478, 22);

    send(8'h81, 1'b1, 1'b1, 6'd1);
    wait_frames(f + 2, "81p1");
    check_frame("81_p1", 1, 11, 16'h0702, 11);

    send(8'h81, 1'b1, 1'b1, 6'd0);
    wait_frames(f + 3, "81p0");
    check_frame("81_p0", 1, 11, 16'h0702, 11);

    repeat (5) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
